alu_mult_sequencer: RTL and testbench

Multi-cycle controller that computes the low 32 bits of a 32x32 product by sequencing the shared combinational ALU through shift-and-add micro-operations. It owns the ALU's control and operand inputs while busy and consumes its result bus. It sits between the issue logic, which supplies operands and a start pulse, and the ALU, and returns the product with a one-cycle valid pulse.

---
 rtl/alu_mult_sequencer.sv | 119 +++++++++++
 tb/tb_alu_mult_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiplier controller: sequences the shared ALU through add and
// shift-left micro-ops to produce the low 32 bits of data_operandA * data_operandB.
module alu_mult_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        ready,
    output logic        result_valid,
    output logic [31:0] data_result,
    output logic [4:0]  ctrl_ALUopcode,
    output logic [4:0]  ctrl_shiftamt,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SLL = 5'b00100;

    state_t      state, state_nxt;
    logic [31:0] m_reg, q_reg, p_reg;
    logic [31:0] m_nxt, q_nxt, p_nxt;
    logic [4:0]  opcode_nxt, shamt_nxt;
    logic [31:0] op_a_nxt, op_b_nxt;

    assign data_result = p_reg;

    always_comb begin
        state_nxt = state;
        m_nxt     = m_reg;
        q_nxt     = q_reg;
        p_nxt     = p_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    m_nxt = data_operandA;
                    q_nxt = data_operandB;
                    p_nxt = '0;
                    if (data_operandB == '0)
                        state_nxt = DONE;
                    else if (data_operandB[0])
                        state_nxt = ADD;
                    else
                        state_nxt = SHIFT;
                end
            end
            ADD: begin
                p_nxt     = alu_result;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                m_nxt = alu_result;
                q_nxt = {1'b0, q_reg[31:1]};
                // q_reg[1] is the multiplier bit that becomes Q[0] after this shift
                if (q_reg[31:1] == '0)
                    state_nxt = DONE;
                else if (q_reg[1])
                    state_nxt = ADD;
                else
                    state_nxt = SHIFT;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drivers are registered, so they are computed from the values the
    // next state will see (P/M as updated on this edge).
    always_comb begin
        opcode_nxt = '0;
        shamt_nxt  = '0;
        op_a_nxt   = '0;
        op_b_nxt   = '0;
        case (state_nxt)
            ADD: begin
                opcode_nxt = OP_ADD;
                op_a_nxt   = p_nxt;
                op_b_nxt   = m_nxt;
            end
            SHIFT: begin
                opcode_nxt = OP_SLL;
                shamt_nxt  = 5'd1;
                op_a_nxt   = m_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            m_reg          <= '0;
            q_reg          <= '0;
            p_reg          <= '0;
            ready          <= 1'b1;
            result_valid   <= 1'b0;
            ctrl_ALUopcode <= '0;
            ctrl_shiftamt  <= '0;
            alu_operandA   <= '0;
            alu_operandB   <= '0;
        end else begin
            state          <= state_nxt;
            m_reg          <= m_nxt;
            q_reg          <= q_nxt;
            p_reg          <= p_nxt;
            ready          <= (state_nxt == IDLE);
            result_valid   <= (state_nxt == DONE);
            ctrl_ALUopcode <= opcode_nxt;
            ctrl_shiftamt  <= shamt_nxt;
            alu_operandA   <= op_a_nxt;
            alu_operandB   <= op_b_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: a behavioural ALU closes the loop,
// and products, latencies and micro-op counts come from plain arithmetic.
module tb_alu_mult_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_operandA, data_operandB;
    logic        ready, result_valid;
    logic [31:0] data_result;
    logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
    logic [31:0] alu_operandA, alu_operandB, alu_result;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    // shared combinational ALU
    always_comb begin
        case (ctrl_ALUopcode)
            5'b00000: alu_result = alu_operandA + alu_operandB;
            5'b00100: alu_result = alu_operandA << ctrl_shiftamt;
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
    end

    alu_mult_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ready          (ready),
        .result_valid   (result_valid),
        .data_result    (data_result),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_result     (alu_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c = 0;
        for (int i = 0; i < 32; i++) c += v[i];
        return c;
    endfunction

    function automatic int unsigned msb_index(input logic [31:0] v);
        int unsigned m = 0;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        return m;
    endfunction

    function automatic int unsigned mult_cycles(input logic [31:0] b);
        return (b == 0) ? 0 : popcount(b) + msb_index(b) + 1;
    endfunction

    task automatic check_alu_idle(input string tag);
        check(tag, {ctrl_ALUopcode, ctrl_shiftamt, alu_operandA, alu_operandB}, '0);
    endtask

    // Issue one multiply and follow it cycle by cycle until ready returns.
    // With poke set, a second start (A=2,B=2) arrives at e0+2 while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        int unsigned n, adds, shifts;
        logic [31:0] exp_p;
        n      = mult_cycles(b);
        exp_p  = a * b;
        adds   = 0;
        shifts = 0;
        @(negedge clock);
        check("ready_before_start", ready, 1);
        data_operandA = a;
        data_operandB = b;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int unsigned k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                check("busy_flags", {ready, result_valid}, 2'b00);
                if (ctrl_ALUopcode == 5'b00100 && ctrl_shiftamt == 5'd1 && alu_operandB == 0)
                    shifts++;
                else if (ctrl_ALUopcode == 5'b00000 && ctrl_shiftamt == 5'd0)
                    adds++;
            end else if (k == n) begin
                check("done_flags", {ready, result_valid}, 2'b01);
                check("product", data_result, exp_p);
                check_alu_idle("done_alu_bus");
            end else begin
                check("idle_flags", {ready, result_valid}, 2'b10);
                check("result_hold", data_result, exp_p);
            end
            if (poke && k == 1) begin
                start = 1'b1;
                data_operandA = 32'd2;
                data_operandB = 32'd2;
            end
            if (poke && k == 2) start = 1'b0;
            if (k <= n) begin
                @(posedge clock); #1;
            end
        end
        check("add_cycles", adds, popcount(b));
        check("shift_cycles", shifts, (b == 0) ? 0 : msb_index(b) + 1);
    endtask

    initial begin
        int unsigned pulses;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_flags", {ready, result_valid}, 2'b10);
        check("reset_result", data_result, 0);
        check_alu_idle("reset_alu_bus");
        reset = 1'b0;

        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd6, 1'b0);

        // start while busy must be dropped: no second pulse afterwards
        run_op(32'd3, 32'd5, 1'b1);
        pulses = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (result_valid || !ready) pulses++;
        end
        check("ignored_start_no_activity", pulses, 0);

        // reset mid-operation aborts with no valid pulse
        @(negedge clock);
        data_operandA = 32'd7;
        data_operandB = 32'hF0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_flags", {ready, result_valid}, 2'b10);
        check("abort_result", data_result, 0);
        check_alu_idle("abort_alu_bus");
        reset = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (result_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run_op(32'd4, 32'd4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 4 == 0) rb = rb & $urandom;
            run_op(ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
